surf4_id_ctrl: RTL and testbench



---
 rtl/surf4_id_ctrl_pkg.sv | 27 ++
 rtl/surf4_id_ctrl_pulse_stretch.sv | 27 ++
 rtl/surf4_id_ctrl.sv | 121 ++++++++++++
 tb/tb_surf4_id_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/surf4_id_ctrl_pkg.sv
// Shared constants for the SURF4 ID/control register block: register map, ID word,
// CTRL bit positions and the bus FSM state encoding.
package surf4_id_ctrl_pkg;

    // Word offsets, i.e. byte offset[15:2]
    localparam logic [13:0] ADR_ID      = 14'h0000;
    localparam logic [13:0] ADR_VERSION = 14'h0001;
    localparam logic [13:0] ADR_SCRATCH = 14'h0002;
    localparam logic [13:0] ADR_CTRL    = 14'h0003;
    localparam logic [13:0] ADR_UPTIME  = 14'h0004;

    localparam logic [31:0] ID_VALUE = 32'h5355_5246;  // "SURF"

    localparam int unsigned CTRL_SRST_BIT = 0;
    localparam int unsigned CTRL_LED_LSB  = 4;
    localparam int unsigned CTRL_LED_MSB  = 7;

    typedef enum logic {
        StIdle,
        StTerm
    } state_t;

    function automatic logic is_mapped(input logic [13:0] word);
        return word <= ADR_UPTIME;
    endfunction

endpackage

// File: rtl/surf4_id_ctrl_pulse_stretch.sv
// Reloadable down-counter: active while the count is non-zero; a load during an
// active pulse restarts the count, extending the pulse.
module surf4_id_ctrl_pulse_stretch #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] len,
    output logic             active
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= len;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign active = (cnt_q != '0);

endmodule

// File: rtl/surf4_id_ctrl.sv
// WISHBONE classic responder for board ID, firmware version, scratch, control and uptime
// registers; drives the soft-reset pulse and LEDs.
module surf4_id_ctrl
    import surf4_id_ctrl_pkg::*;
#(
    parameter logic [31:0] FW_VERSION = 32'h0000_0001,
    parameter int unsigned RST_PULSE  = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [19:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        wb_rty_o,
    output logic        soft_rst_o,
    output logic [3:0]  led_o
);

    state_t      state_q;
    logic [13:0] adr_q;
    logic        we_q;
    logic [31:0] dat_q;
    logic [3:0]  sel_q;
    logic        mapped_q;
    logic [31:0] rdata_q;
    logic [31:0] scratch_q;
    logic [3:0]  led_q;
    logic [31:0] uptime_q;
    logic [31:0] rd_mux;
    logic [13:0] word;
    logic        commit;
    logic        srst_load;

    logic unused_adr;
    assign unused_adr = ^{wb_adr_i[19:16], wb_adr_i[1:0]};

    assign word = wb_adr_i[15:2];

    always_comb begin
        rd_mux = 32'h0;
        case (word)
            ADR_ID:      rd_mux = ID_VALUE;
            ADR_VERSION: rd_mux = FW_VERSION;
            ADR_SCRATCH: rd_mux = scratch_q;
            ADR_CTRL:    rd_mux = {24'h0, led_q, 4'h0};
            ADR_UPTIME:  rd_mux = uptime_q;
            default:     rd_mux = 32'h0;
        endcase
    end

    // Termination is withheld if the master drops cyc during TERM or reset hits mid-transfer.
    assign commit   = (state_q == StTerm) && wb_cyc_i && !rst_i;
    assign wb_ack_o = commit && mapped_q;
    assign wb_err_o = commit && !mapped_q;
    assign wb_rty_o = 1'b0;
    assign wb_dat_o = rdata_q;
    assign led_o    = led_q;

    assign srst_load = commit && we_q && (adr_q == ADR_CTRL) && sel_q[0] && dat_q[CTRL_SRST_BIT];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            adr_q     <= '0;
            we_q      <= 1'b0;
            dat_q     <= '0;
            sel_q     <= '0;
            mapped_q  <= 1'b0;
            rdata_q   <= '0;
            scratch_q <= '0;
            led_q     <= '0;
            uptime_q  <= '0;
        end else begin
            uptime_q <= uptime_q + 32'd1;
            case (state_q)
                StIdle: begin
                    if (wb_cyc_i && wb_stb_i) begin
                        adr_q    <= word;
                        we_q     <= wb_we_i;
                        dat_q    <= wb_dat_i;
                        sel_q    <= wb_sel_i;
                        mapped_q <= is_mapped(word);
                        rdata_q  <= rd_mux;
                        state_q  <= StTerm;
                    end
                end
                StTerm: begin
                    state_q <= StIdle;
                    if (wb_cyc_i && we_q && mapped_q) begin
                        if (adr_q == ADR_SCRATCH) begin
                            for (int b = 0; b < 4; b++) begin
                                if (sel_q[b]) scratch_q[8*b +: 8] <= dat_q[8*b +: 8];
                            end
                        end
                        if (adr_q == ADR_CTRL && sel_q[0]) begin
                            led_q <= dat_q[CTRL_LED_MSB:CTRL_LED_LSB];
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    surf4_id_ctrl_pulse_stretch #(
        .CNT_W(8)
    ) u_srst (
        .clk    (clk_i),
        .rst    (rst_i),
        .load   (srst_load),
        .len    (8'(RST_PULSE)),
        .active (soft_rst_o)
    );

endmodule

// File: tb/tb_surf4_id_ctrl.sv
// Scoreboard bench for surf4_id_ctrl: expected terminations are queued at strobe time and
// popped by a monitor when the DUT terminates a cycle.
module tb_surf4_id_ctrl;

    localparam logic [31:0] FW = 32'h0102_0304;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we  = 1'b0;
    logic [19:0] adr = '0;
    logic [31:0] wdat = '0;
    logic [3:0]  sel = '0;
    logic [31:0] rdat;
    logic        ack;
    logic        err;
    logic        rty;
    logic        srst;
    logic [3:0]  led;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        err;
        logic        rd;
        logic [31:0] dat;
    } exp_t;

    exp_t sb_q[$];

    int run_len  = 0;
    int last_run = 0;

    always #5 clk = ~clk;

    surf4_id_ctrl #(
        .FW_VERSION (FW),
        .RST_PULSE  (16)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .wb_cyc_i   (cyc),
        .wb_stb_i   (stb),
        .wb_we_i    (we),
        .wb_adr_i   (adr),
        .wb_dat_i   (wdat),
        .wb_sel_i   (sel),
        .wb_dat_o   (rdat),
        .wb_ack_o   (ack),
        .wb_err_o   (err),
        .wb_rty_o   (rty),
        .soft_rst_o (srst),
        .led_o      (led)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (ack || err) begin
            if (sb_q.size() == 0) begin
                check("unexpected_term", {30'h0, ack, err}, 32'h0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("term_kind", {30'h0, ack, err}, e.err ? 32'h1 : 32'h2);
                if (e.rd && !e.err) check("rdata", rdat, e.dat);
            end
        end
    end

    // soft_rst_o pulse length measurement
    always @(negedge clk) begin
        if (srst) begin
            run_len <= run_len + 1;
        end else if (run_len != 0) begin
            last_run <= run_len;
            run_len  <= 0;
        end
    end

    task automatic xfer(input logic w, input logic [19:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic exp_err, input logic [31:0] exp_dat);
        exp_t e;
        e.err = exp_err;
        e.rd  = !w;
        e.dat = exp_dat;
        sb_q.push_back(e);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
        @(negedge clk);
        check("latency", {31'h0, ack | err}, 32'h1);
        @(posedge clk);
        #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [19:0] a, input logic [31:0] exp_dat);
        xfer(1'b0, a, 32'h0, 4'h0, 1'b0, exp_dat);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ack", {31'h0, ack}, 32'h0);
        check("rst_err", {31'h0, err}, 32'h0);
        check("rst_rty", {31'h0, rty}, 32'h0);
        check("rst_dat", rdat, 32'h0);
        check("rst_srst", {31'h0, srst}, 32'h0);
        check("rst_led", {28'h0, led}, 32'h0);

        rd(20'h00000, 32'h5355_5246);
        rd(20'h00004, FW);
        rd(20'h10000, 32'h5355_5246);  // upper address bits ignored
        rd(20'h00008, 32'h0);

        xfer(1'b1, 20'h00008, 32'hA5A5_A5A5, 4'b0101, 1'b0, 32'h0);
        rd(20'h00008, 32'h00A5_00A5);
        xfer(1'b1, 20'h00008, 32'hFFFF_FFFF, 4'b0000, 1'b0, 32'h0);
        rd(20'h00008, 32'h00A5_00A5);
        xfer(1'b1, 20'h00000, 32'h0, 4'hF, 1'b0, 32'h0);
        rd(20'h00000, 32'h5355_5246);

        xfer(1'b0, 20'h00020, 32'h0, 4'h0, 1'b1, 32'h0);
        xfer(1'b1, 20'h0FFFC, 32'hDEAD_BEEF, 4'hF, 1'b1, 32'h0);
        xfer(1'b1, 20'h00014, 32'hDEAD_BEEF, 4'hF, 1'b1, 32'h0);
        rd(20'h00008, 32'h00A5_00A5);

        // Single soft-reset pulse
        xfer(1'b1, 20'h0000C, 32'h0000_00F1, 4'b0001, 1'b0, 32'h0);
        @(negedge clk);
        check("srst_start", {31'h0, srst}, 32'h1);
        repeat (20) @(negedge clk);
        check("srst_len", last_run, 16);
        check("led", {28'h0, led}, 32'hF);
        rd(20'h0000C, 32'h0000_00F0);

        // Retrigger at pulse cycle 10
        xfer(1'b1, 20'h0000C, 32'h0000_00F1, 4'b0001, 1'b0, 32'h0);
        repeat (8) @(negedge clk);
        xfer(1'b1, 20'h0000C, 32'h0000_00F1, 4'b0001, 1'b0, 32'h0);
        repeat (35) @(negedge clk);
        check("srst_retrig_len", last_run, 26);

        // Master drops cyc during TERM of a scratch write
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 20'h00008; wdat = 32'h1111_1111; sel = 4'hF;
        @(posedge clk);
        #1 cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        check("abort_ack", {31'h0, ack}, 32'h0);
        rd(20'h00008, 32'h00A5_00A5);

        // Reset during TERM
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 20'h00008; wdat = 32'h2222_2222; sel = 4'hF;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_term_ack", {30'h0, ack, err}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        rd(20'h00008, 32'h0);
        check("rst_term_led", {28'h0, led}, 32'h0);

        // Uptime wrap
        @(negedge clk);
        force dut.uptime_q = 32'hFFFF_FFFE;
        @(posedge clk);
        #1 release dut.uptime_q;
        rd(20'h00010, 32'hFFFF_FFFE);
        rd(20'h00010, 32'h0000_0000);

        repeat (3) @(negedge clk);
        check("sb_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
